filereg_stream_arbiter: RTL and testbench

//  Merges NumChannels FileReg streams (valid/ready/data/last) into one FileReg manager stream.

---
 rtl/filereg_stream_arbiter_if.sv | 30 +++
 rtl/filereg_stream_arbiter.sv | 143 ++++++++++++++
 tb/tb_filereg_stream_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filereg_stream_arbiter_if.sv
// FileReg multi-channel stream bundle: NumChannels subordinate streams in, one manager stream out.
interface filereg_stream_arbiter_if #(
    parameter int unsigned DataSize    = 32,
    parameter int unsigned NumChannels = 4
) ();
    localparam int unsigned ChIdSize = $clog2(NumChannels);

    logic [NumChannels-1:0]          s_valid;
    logic [NumChannels-1:0]          s_ready;
    logic [NumChannels*DataSize-1:0] s_data;
    logic [NumChannels-1:0]          s_last;

    logic                            m_valid;
    logic                            m_ready;
    logic [DataSize-1:0]             m_data;
    logic                            m_last;
    logic [ChIdSize-1:0]             m_channel;

    // Arbiter side: accepts the channel streams, drives the merged stream.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_channel
    );

    // Environment side: sources the channel streams, sinks the merged stream.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_channel
    );
endinterface

// File: rtl/filereg_stream_arbiter.sv
// Merges NumChannels FileReg streams into one, forwarding whole packets per
// channel with packet-locked round-robin arbitration and per-channel FIFOs.
module filereg_stream_arbiter #(
    parameter int unsigned DataSize    = 32,
    parameter int unsigned NumChannels = 4,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    filereg_stream_arbiter_if.slave bus
);
    localparam int unsigned ChIdSize  = $clog2(NumChannels);
    localparam int unsigned CntSize   = $clog2(FifoDepth) + 1;
    localparam int unsigned PtrSize   = $clog2(FifoDepth);
    localparam int unsigned EntrySize = DataSize + 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    // Per-channel FIFO storage; entry = {last, data}
    logic [EntrySize-1:0] mem_q    [NumChannels][FifoDepth];
    logic [PtrSize-1:0]   wr_ptr_q [NumChannels];
    logic [PtrSize-1:0]   rd_ptr_q [NumChannels];
    logic [CntSize-1:0]   count_q  [NumChannels];

    state_t               state_q;
    logic [ChIdSize-1:0]  grant_q;
    logic [ChIdSize-1:0]  last_grant_q;

    logic [NumChannels-1:0] s_ready_c;
    logic [NumChannels-1:0] push_c;
    logic [NumChannels-1:0] pop_c;
    logic                   any_c;
    logic [ChIdSize-1:0]    next_grant_c;
    logic [EntrySize-1:0]   head_c;
    logic                   m_valid_c;
    logic                   pop_last_c;

    // Input acceptance: ready while the channel FIFO has room and reset is released
    always_comb begin
        s_ready_c = '0;
        push_c    = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            s_ready_c[i] = !rst && (count_q[i] != CntSize'(FifoDepth));
            push_c[i]    = bus.s_valid[i] && s_ready_c[i];
        end
    end

    // Round-robin search starting just after the channel served last
    always_comb begin
        any_c        = 1'b0;
        next_grant_c = last_grant_q;
        for (int unsigned k = 1; k <= NumChannels; k++) begin
            logic [ChIdSize-1:0] cand;
            cand = ChIdSize'((32'(last_grant_q) + k) % NumChannels);
            if (!any_c && (count_q[cand] != '0)) begin
                any_c        = 1'b1;
                next_grant_c = cand;
            end
        end
    end

    // Head of the granted FIFO and output handshake decode
    always_comb begin
        head_c     = mem_q[grant_q][rd_ptr_q[grant_q]];
        m_valid_c  = (state_q == ST_LOCKED) && (count_q[grant_q] != '0);
        pop_last_c = m_valid_c && bus.m_ready && head_c[DataSize];
        pop_c      = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (grant_q == ChIdSize'(i)) begin
                pop_c[i] = m_valid_c && bus.m_ready;
            end
        end
    end

    // Output bus is forced to zero whenever no word is offered
    assign bus.s_ready   = s_ready_c;
    assign bus.m_valid   = m_valid_c;
    assign bus.m_data    = m_valid_c ? head_c[DataSize-1:0] : '0;
    assign bus.m_last    = m_valid_c ? head_c[DataSize] : 1'b0;
    assign bus.m_channel = m_valid_c ? grant_q : '0;

    // FIFO payload write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (push_c[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {bus.s_last[i], bus.s_data[i*DataSize +: DataSize]};
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (push_c[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PtrSize'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PtrSize'(1);
                end
                case ({push_c[i], pop_c[i]})
                    2'b10:   count_q[i] <= count_q[i] + CntSize'(1);
                    2'b01:   count_q[i] <= count_q[i] - CntSize'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // Packet-locked arbiter: grant holds until the last word of the packet pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ChIdSize'(NumChannels - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        grant_q <= next_grant_c;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (pop_last_c) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filereg_stream_arbiter.sv
// Directed bench for filereg_stream_arbiter (DataSize 32, 4 channels, depth 4).
module tb_filereg_stream_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned NC = 4;

    typedef struct packed {
        logic [1:0]  ch;
        logic        last;
        logic [31:0] data;
    } xfer_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    filereg_stream_arbiter_if #(.DataSize(DW), .NumChannels(NC)) bus ();

    filereg_stream_arbiter #(.DataSize(DW), .NumChannels(NC), .FifoDepth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {valid, channel, last, data}
    logic [35:0] obs;
    assign obs = {bus.m_valid, bus.m_channel, bus.m_last, bus.m_data};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        bus.s_valid = '0;
        bus.s_data  = '0;
        bus.s_last  = '0;
    endtask

    task automatic drive_ch(input int ch, input logic [31:0] d, input logic l);
        bus.s_valid[ch]           = 1'b1;
        bus.s_data[ch*DW +: DW]   = d;
        bus.s_last[ch]            = l;
    endtask

    task automatic do_reset();
        clear_inputs();
        bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.m_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 36'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 36'h0);
        else n_pass++;
        n_checks++;
        if (bus.s_ready !== 4'h0) $display("FAIL reset_s_ready: got %b expected %b", bus.s_ready, 4'h0);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.s_ready !== 4'hF) $display("FAIL reset_release_s_ready: got %b expected %b", bus.s_ready, 4'hF);
        else n_pass++;
        n_checks++;
        if (obs !== 36'h0) $display("FAIL reset_release_idle: got %h expected %h", obs, 36'h0);
        else n_pass++;
    endtask

    // T1: 3-word packet on ch2 with 2-cycle latency and 1 word/cycle
    task automatic test_single_packet();
        do_reset();
        bus.m_ready = 1'b1;
        @(negedge clk);
        drive_ch(2, 32'hA1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (obs !== 36'h0) $display("FAIL t1_latency_gap: got %h expected %h", obs, 36'h0);
        else n_pass++;
        drive_ch(2, 32'hA2, 1'b0);
        @(negedge clk);
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b0, 32'hA1}) $display("FAIL t1_word0: got %h expected %h", obs, {1'b1, 2'd2, 1'b0, 32'hA1});
        else n_pass++;
        drive_ch(2, 32'hA3, 1'b1);
        @(negedge clk);
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b0, 32'hA2}) $display("FAIL t1_word1: got %h expected %h", obs, {1'b1, 2'd2, 1'b0, 32'hA2});
        else n_pass++;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (obs !== {1'b1, 2'd2, 1'b1, 32'hA3}) $display("FAIL t1_word2_last: got %h expected %h", obs, {1'b1, 2'd2, 1'b1, 32'hA3});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== 36'h0) $display("FAIL t1_after_last_zero: got %h expected %h", obs, 36'h0);
        else n_pass++;
    endtask

    // T2: four single-word packets, round-robin from ch0 with a bubble between
    task automatic test_round_robin();
        do_reset();
        bus.m_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_ch(i, 32'hB0 + 32'(i), 1'b1);
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (obs !== 36'h0) $display("FAIL t2_idle_first: got %h expected %h", obs, 36'h0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== {1'b1, 2'(i), 1'b1, 32'hB0 + 32'(i)})
                $display("FAIL t2_word_ch%0d: got %h expected %h", i, obs, {1'b1, 2'(i), 1'b1, 32'hB0 + 32'(i)});
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (bus.m_valid !== 1'b0) $display("FAIL t2_bubble_%0d: got %b expected %b", i, bus.m_valid, 1'b0);
            else n_pass++;
        end
    endtask

    // T3: ch1 packet stalls mid-way; ch0 must wait until ch1's last word
    task automatic test_packet_lock();
        xfer_t q[$];
        xfer_t exp_q[4];
        do_reset();
        bus.m_ready = 1'b1;
        exp_q[0] = {2'd1, 1'b0, 32'h10};
        exp_q[1] = {2'd1, 1'b0, 32'h11};
        exp_q[2] = {2'd1, 1'b1, 32'h12};
        exp_q[3] = {2'd0, 1'b1, 32'h20};
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            clear_inputs();
            if (c == 0) drive_ch(1, 32'h10, 1'b0);
            if (c == 1) begin
                drive_ch(1, 32'h11, 1'b0);
                drive_ch(0, 32'h20, 1'b1);
            end
            if (c == 7) drive_ch(1, 32'h12, 1'b1);
            #1;
            if (bus.m_valid && bus.m_ready) q.push_back({bus.m_channel, bus.m_last, bus.m_data});
        end
        clear_inputs();
        n_checks++;
        if (q.size() !== 4) $display("FAIL t3_count: got %0d expected %0d", q.size(), 4);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= q.size()) $display("FAIL t3_xfer%0d: got none expected %h", i, exp_q[i]);
            else if (q[i] !== exp_q[i]) $display("FAIL t3_xfer%0d: got %h expected %h", i, q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    // T4: ch3 fills its FIFO under backpressure, then drains
    task automatic test_backpressure();
        xfer_t q[$];
        int    src_idx;
        logic  acc;
        do_reset();
        src_idx = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.m_ready = (c >= 10);
            if (src_idx < 5) drive_ch(3, 32'h30 + 32'(src_idx), src_idx == 4);
            #1;
            acc = bus.s_valid[3] && bus.s_ready[3];
            if (c == 4 || c == 10) begin
                n_checks++;
                if (bus.s_ready[3] !== 1'b0) $display("FAIL t4_full_c%0d: got %b expected %b", c, bus.s_ready[3], 1'b0);
                else n_pass++;
            end
            if (c == 11) begin
                n_checks++;
                if (bus.s_ready[3] !== 1'b1) $display("FAIL t4_ready_after_pop: got %b expected %b", bus.s_ready[3], 1'b1);
                else n_pass++;
            end
            if (c == 9) begin
                n_checks++;
                if (src_idx !== 4) $display("FAIL t4_accepted: got %0d expected %0d", src_idx, 4);
                else n_pass++;
                n_checks++;
                if (obs !== {1'b1, 2'd3, 1'b0, 32'h30}) $display("FAIL t4_hold_head: got %h expected %h", obs, {1'b1, 2'd3, 1'b0, 32'h30});
                else n_pass++;
            end
            if (bus.m_valid && bus.m_ready) q.push_back({bus.m_channel, bus.m_last, bus.m_data});
            if (acc) src_idx++;
        end
        clear_inputs();
        n_checks++;
        if (q.size() !== 5) $display("FAIL t4_count: got %0d expected %0d", q.size(), 5);
        else n_pass++;
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            n_checks++;
            if (q[i] !== {2'd3, i == 4, 32'h30 + 32'(i)})
                $display("FAIL t4_xfer%0d: got %h expected %h", i, q[i], {2'd3, i == 4, 32'h30 + 32'(i)});
            else n_pass++;
        end
    endtask

    // T5: irregular m_ready over an 8-word packet; offered word must always be the next expected one
    task automatic test_ready_toggle();
        logic [31:0] rpat;
        logic [35:0] exp_obs;
        int          src_idx;
        int          n_xfer;
        logic        acc;
        do_reset();
        rpat    = 32'b1011_0010_0110_1001_1100_0101_1010_0011;
        src_idx = 0;
        n_xfer  = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.m_ready = rpat[c % 32];
            if (src_idx < 8) drive_ch(0, 32'h50 + 32'(src_idx), src_idx == 7);
            #1;
            acc = bus.s_valid[0] && bus.s_ready[0];
            if (bus.m_valid) begin
                exp_obs = {1'b1, 2'd0, n_xfer == 7, 32'h50 + 32'(n_xfer)};
                n_checks++;
                if (n_xfer >= 8 || obs !== exp_obs) $display("FAIL t5_word_c%0d: got %h expected %h", c, obs, exp_obs);
                else n_pass++;
                if (bus.m_ready) n_xfer++;
            end
            if (acc) src_idx++;
        end
        clear_inputs();
        n_checks++;
        if (n_xfer !== 8) $display("FAIL t5_count: got %0d expected %0d", n_xfer, 8);
        else n_pass++;
    endtask

    // T6: reset mid-packet drops everything; ch0 regains first priority
    task automatic test_reset_mid_packet();
        do_reset();
        bus.m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            drive_ch(1, 32'h60 + 32'(c), c == 3);
            #1;
            if (c >= 2) begin
                n_checks++;
                if (obs !== {1'b1, 2'd1, 1'b0, 32'h60 + 32'(c - 2)})
                    $display("FAIL t6_pre_word%0d: got %h expected %h", c - 2, obs, {1'b1, 2'd1, 1'b0, 32'h60 + 32'(c - 2)});
                else n_pass++;
            end
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 36'h0) $display("FAIL t6_rst_outputs: got %h expected %h", obs, 36'h0);
        else n_pass++;
        n_checks++;
        if (bus.s_ready !== 4'h0) $display("FAIL t6_rst_s_ready: got %b expected %b", bus.s_ready, 4'h0);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_valid !== 1'b0) $display("FAIL t6_stale_c%0d: got %b expected %b", c, bus.m_valid, 1'b0);
            else n_pass++;
        end
        n_checks++;
        if (bus.s_ready !== 4'hF) $display("FAIL t6_fifos_empty: got %b expected %b", bus.s_ready, 4'hF);
        else n_pass++;
        drive_ch(3, 32'h73, 1'b1);
        drive_ch(0, 32'h70, 1'b1);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (obs !== {1'b1, 2'd0, 1'b1, 32'h70}) $display("FAIL t6_prio_ch0: got %h expected %h", obs, {1'b1, 2'd0, 1'b1, 32'h70});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== {1'b1, 2'd3, 1'b1, 32'h73}) $display("FAIL t6_then_ch3: got %h expected %h", obs, {1'b1, 2'd3, 1'b1, 32'h73});
        else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_ready_toggle();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
